shared_reg_arbiter: RTL

- Round-robin arbiter and write controller for one shared W-bit storage register.
- Shares the register among N requesters using a req/gnt handshake.
- Bounds each ownership with a hold timeout and inserts a one-cycle gap between owners.
- Sits between requester logic and the negedge-clocked register datapath, so every state update is on the falling edge of clk.

---
 rtl/shared_reg_arbiter_pkg.sv | 17 +
 rtl/shared_reg_arbiter_if.sv | 28 ++
 rtl/shared_reg_arbiter_rr_pick.sv | 27 ++
 rtl/shared_reg_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and default parameter values for the shared register arbiter.
// State encodings are fixed so that debug dumps read the same across revisions.
package shared_reg_arbiter_pkg;

   localparam int DEF_N        = 4;
   localparam int DEF_IDX_W    = 2;
   localparam int DEF_W        = 8;
   localparam int DEF_MAX_HOLD = 8;
   localparam int DEF_CNT_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bundle of the shared register arbiter: requests, write port
// and the grant/status/register outputs.
interface shared_reg_arbiter_if
   import shared_reg_arbiter_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int IDX_W = DEF_IDX_W,
   parameter int W     = DEF_W
);
   logic [N-1:0]   req;
   logic [N-1:0]   wr_en;
   logic [N*W-1:0] wr_data;
   logic [N-1:0]   gnt;
   logic [IDX_W-1:0] owner;
   logic           busy;
   logic [W-1:0]   q;
   logic           timeout;

   modport master (
      output req, wr_en, wr_data,
      input  gnt, owner, busy, q, timeout
   );

   modport slave (
      input  req, wr_en, wr_data,
      output gnt, owner, busy, q, timeout
   );
endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Round-robin pick: first set request bit scanning upward from ptr, wrapping
// from N-1 back to 0.
module rr_pick
   import shared_reg_arbiter_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int IDX_W = DEF_IDX_W
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] winner,
   output logic             valid
);

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            winner = IDX_W'((int'(ptr) + k) % N);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write controller for one shared W-bit register.
// All state moves on the falling edge of clk to match the register datapath.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner; arbitrate among req at the next falling edge
// ST_GRANT | owner holds gnt; writes accepted; hold counter running
// ST_GAP   | one dead cycle between owners, requests ignored
module shared_reg_arbiter
   import shared_reg_arbiter_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int IDX_W    = DEF_IDX_W,
   parameter int W        = DEF_W,
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   shared_reg_arbiter_if.slave bus
);

   arb_state_t       state_q, state_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic             busy_q, busy_d;
   logic [W-1:0]     q_q, q_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;

   logic [IDX_W-1:0] pick_winner;
   logic             pick_valid;
   logic             sel_req;
   logic             sel_wen;
   logic [W-1:0]     sel_data;
   logic [IDX_W-1:0] ptr_after_owner;

   rr_pick #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req    (bus.req),
      .ptr    (ptr_q),
      .winner (pick_winner),
      .valid  (pick_valid)
   );

   always_comb begin
      sel_req  = 1'b0;
      sel_wen  = 1'b0;
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (owner_q == IDX_W'(i)) begin
            sel_req  = bus.req[i];
            sel_wen  = bus.wr_en[i];
            sel_data = bus.wr_data[i*W +: W];
         end
      end
   end

   assign ptr_after_owner = (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + 1'b1;

   always_ff @(negedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         owner_q   <= '0;
         busy_q    <= 1'b0;
         q_q       <= '0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
         ptr_q     <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         busy_q    <= busy_d;
         q_q       <= q_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      busy_d    = busy_q;
      q_d       = q_q;
      timeout_d = 1'b0;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               gnt_d = '0;
               for (int i = 0; i < N; i++) begin
                  if (pick_winner == IDX_W'(i)) gnt_d[i] = 1'b1;
               end
               owner_d = pick_winner;
               busy_d  = 1'b1;
               cnt_d   = CNT_W'(1);
               state_d = ST_GRANT;
            end
         end

         ST_GRANT: begin
            // A write racing the owner's own release is dropped.
            if (sel_wen && sel_req) q_d = sel_data;
            if (!sel_req) begin
               gnt_d   = '0;
               busy_d  = 1'b0;
               ptr_d   = ptr_after_owner;
               state_d = ST_GAP;
            end else if (cnt_q == CNT_W'(MAX_HOLD)) begin
               gnt_d     = '0;
               busy_d    = 1'b0;
               timeout_d = 1'b1;
               ptr_d     = ptr_after_owner;
               state_d   = ST_GAP;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_GAP: begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.gnt     = gnt_q;
   assign bus.owner   = owner_q;
   assign bus.busy    = busy_q;
   assign bus.q       = q_q;
   assign bus.timeout = timeout_q;

endmodule
